// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: autonomous L0/xmem instruction sequencer for the kij loop.
// Walks every kernel position through weight load, gap, activation load and
// drain, then issues one accumulation readout and a done pulse.
//
// Optional feature macro: SEQ_ABORT_EN (adds the abort input).
//
// Ports
//   clk, reset          clock / synchronous active-high reset
//   start, stall        sequence start (IDLE only) / L0 backpressure
//   cfg_*               run configuration, latched on an accepted start
//   abort               (SEQ_ABORT_EN only) return to IDLE without done
//   CEN_xmem, WEN_xmem  xmem chip/write enables, active-low
//   A_xmem, inst_w      xmem address and L0 instruction (01 kernel, 10 act)
//   kij, is_os          current kernel position / latched OS mode
//   readout_start, done one-cycle pulses; busy high outside IDLE
module core_seq_ctrl #(
    parameter int unsigned COL       = 8,
    parameter int unsigned ADDR_W    = 11,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned GAP_CYC   = 10,
    parameter int unsigned DRAIN_CYC = 30
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stall,
    input  logic [3:0]        cfg_len_kij,
    input  logic [CNT_W-1:0]  cfg_len_nij,
    input  logic [CNT_W-1:0]  cfg_len_onij,
    input  logic [ADDR_W-1:0] cfg_x_base,
    input  logic [ADDR_W-1:0] cfg_w_base,
    input  logic              cfg_is_os,
`ifdef SEQ_ABORT_EN
    input  logic              abort,
`endif
    output logic              CEN_xmem,
    output logic              WEN_xmem,
    output logic [ADDR_W-1:0] A_xmem,
    output logic [1:0]        inst_w,
    output logic [3:0]        kij,
    output logic              is_os,
    output logic              readout_start,
    output logic              busy,
    output logic              done
);

    localparam int unsigned W_COL = $clog2(COL + 1);
    localparam int unsigned W_GAP = $clog2(GAP_CYC + 1);
    localparam int unsigned W_DRN = $clog2(DRAIN_CYC + 1);
    localparam int unsigned W_A   = (CNT_W > W_COL) ? CNT_W : W_COL;
    localparam int unsigned W_B   = (W_GAP > W_DRN) ? W_GAP : W_DRN;
    localparam int unsigned W_CNT = (W_A > W_B) ? W_A : W_B;

    localparam logic [W_CNT-1:0] C_COL_LAST = W_CNT'(COL - 1);
    localparam logic [W_CNT-1:0] C_GAP_LAST = W_CNT'(GAP_CYC - 1);
    localparam logic [W_CNT-1:0] C_DRN_LAST = W_CNT'(DRAIN_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WLOAD, S_WGAP, S_XLOAD, S_DRAIN, S_RDOUT, S_DONE
    } state_t;

    state_t             r_state, w_state;
    logic [W_CNT-1:0]   r_cnt, w_cnt;
    logic               r_sup, w_sup;       // current load cycle is a stall bubble
    logic [3:0]         r_kij, w_kij;
    logic [ADDR_W-1:0]  r_waddr, w_waddr;   // runs across kij: base + kij*COL + t
    logic [ADDR_W-1:0]  r_xaddr, w_xaddr;

    logic [3:0]         r_len_kij, w_len_kij;
    logic [CNT_W-1:0]   r_len_nij, w_len_nij;
    logic [CNT_W-1:0]   r_len_onij, w_len_onij;
    logic [ADDR_W-1:0]  r_x_base, w_x_base;
    logic               r_is_os, w_is_os;

    logic               r_cen, w_cen_o;
    logic [1:0]         r_inst, w_inst_o;
    logic [ADDR_W-1:0]  r_addr, w_addr_o;
    logic [3:0]         r_kij_o;
    logic               r_is_os_o;
    logic               r_rs, w_rs_o;
    logic               r_busy, w_busy_o;
    logic               r_done, w_done_o;
    logic               w_abort;

`ifdef SEQ_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // State, counters and latched configuration
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_sup      <= 1'b0;
            r_kij      <= '0;
            r_waddr    <= '0;
            r_xaddr    <= '0;
            r_len_kij  <= '0;
            r_len_nij  <= '0;
            r_len_onij <= '0;
            r_x_base   <= '0;
            r_is_os    <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_sup      <= w_sup;
            r_kij      <= w_kij;
            r_waddr    <= w_waddr;
            r_xaddr    <= w_xaddr;
            r_len_kij  <= w_len_kij;
            r_len_nij  <= w_len_nij;
            r_len_onij <= w_len_onij;
            r_x_base   <= w_x_base;
            r_is_os    <= w_is_os;
        end
    end

    // Output registers: present the decode of the state held during the last cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cen     <= 1'b1;
            r_inst    <= 2'b00;
            r_addr    <= '0;
            r_kij_o   <= '0;
            r_is_os_o <= 1'b0;
            r_rs      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_cen     <= w_cen_o;
            r_inst    <= w_inst_o;
            r_addr    <= w_addr_o;
            r_kij_o   <= r_kij;
            r_is_os_o <= r_is_os;
            r_rs      <= w_rs_o;
            r_busy    <= w_busy_o;
            r_done    <= w_done_o;
        end
    end

    // Next state, counters and next output values
    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_sup      = 1'b0;
        w_kij      = r_kij;
        w_waddr    = r_waddr;
        w_xaddr    = r_xaddr;
        w_len_kij  = r_len_kij;
        w_len_nij  = r_len_nij;
        w_len_onij = r_len_onij;
        w_x_base   = r_x_base;
        w_is_os    = r_is_os;
        w_cen_o    = 1'b1;
        w_inst_o   = 2'b00;
        w_addr_o   = r_addr;
        w_rs_o     = 1'b0;
        w_done_o   = 1'b0;
        w_busy_o   = (r_state != S_IDLE);

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_len_kij  = cfg_len_kij;
                    w_len_nij  = cfg_len_nij;
                    w_len_onij = cfg_len_onij;
                    w_x_base   = cfg_x_base;
                    w_is_os    = cfg_is_os;
                    w_waddr    = cfg_w_base;
                    w_kij      = '0;
                    w_cnt      = '0;
                    w_state    = (cfg_len_kij == 4'd0) ? S_DONE : S_WLOAD;
                end
            end
            S_WLOAD: begin
                // A bubble holds counter and address so the word is re-issued
                if (!r_sup) begin
                    w_cen_o  = 1'b0;
                    w_inst_o = 2'b01;
                    w_addr_o = r_waddr;
                    w_waddr  = r_waddr + ADDR_W'(1);
                    if (r_cnt == C_COL_LAST) begin
                        w_state = S_WGAP;
                        w_cnt   = '0;
                    end else begin
                        w_cnt = r_cnt + W_CNT'(1);
                        w_sup = stall;
                    end
                end else begin
                    w_sup = stall;
                end
            end
            S_WGAP: begin
                if (r_cnt == C_GAP_LAST) begin
                    w_cnt   = '0;
                    w_xaddr = r_x_base;
                    w_state = (r_len_nij == '0) ? S_DRAIN : S_XLOAD;
                end else begin
                    w_cnt = r_cnt + W_CNT'(1);
                end
            end
            S_XLOAD: begin
                if (!r_sup) begin
                    w_cen_o  = 1'b0;
                    w_inst_o = 2'b10;
                    w_addr_o = r_xaddr;
                    w_xaddr  = r_xaddr + ADDR_W'(1);
                    if (r_cnt == W_CNT'(r_len_nij - CNT_W'(1))) begin
                        w_state = S_DRAIN;
                        w_cnt   = '0;
                    end else begin
                        w_cnt = r_cnt + W_CNT'(1);
                        w_sup = stall;
                    end
                end else begin
                    w_sup = stall;
                end
            end
            S_DRAIN: begin
                if (r_cnt == C_DRN_LAST) begin
                    w_cnt = '0;
                    if (r_kij == r_len_kij - 4'd1) begin
                        w_state = S_RDOUT;
                    end else begin
                        w_kij   = r_kij + 4'd1;
                        w_state = S_WLOAD;
                    end
                end else begin
                    w_cnt = r_cnt + W_CNT'(1);
                end
            end
            S_RDOUT: begin
                w_rs_o = (r_cnt == '0);
                if (r_cnt == W_CNT'(r_len_onij)) begin
                    w_cnt   = '0;
                    w_state = S_DONE;
                end else begin
                    w_cnt = r_cnt + W_CNT'(1);
                end
            end
            S_DONE: begin
                w_done_o = 1'b1;
                w_state  = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        // Abort wins over everything except reset and leaves without any pulse
        if (w_abort && (r_state != S_IDLE)) begin
            w_state  = S_IDLE;
            w_cnt    = '0;
            w_sup    = 1'b0;
            w_cen_o  = 1'b1;
            w_inst_o = 2'b00;
            w_addr_o = r_addr;
            w_rs_o   = 1'b0;
            w_done_o = 1'b0;
            w_busy_o = 1'b0;
        end
    end

    assign CEN_xmem      = r_cen;
    assign WEN_xmem      = 1'b1;
    assign A_xmem        = r_addr;
    assign inst_w        = r_inst;
    assign kij           = r_kij_o;
    assign is_os         = r_is_os_o;
    assign readout_start = r_rs;
    assign busy          = r_busy;
    assign done          = r_done;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Self-checking bench for core_seq_ctrl: builds the expected per-cycle output
// trace from the sequence rules (ordered word lists, gap lengths, stall bubbles)
// and compares the DUT against it cycle by cycle.
module tb_core_seq_ctrl;

    localparam int unsigned COL   = 8;
    localparam int unsigned GAP   = 10;
    localparam int unsigned DRN   = 30;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        abort = 1'b0;
    logic [3:0]  cfg_len_kij = '0;
    logic [7:0]  cfg_len_nij = '0;
    logic [7:0]  cfg_len_onij = '0;
    logic [10:0] cfg_x_base = '0;
    logic [10:0] cfg_w_base = '0;
    logic        cfg_is_os = 1'b0;
    logic        CEN_xmem, WEN_xmem, is_os, readout_start, busy, done;
    logic [10:0] A_xmem;
    logic [1:0]  inst_w;
    logic [3:0]  kij;

    core_seq_ctrl #(.COL(COL), .ADDR_W(11), .CNT_W(8), .GAP_CYC(GAP), .DRAIN_CYC(DRN)) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .cfg_len_kij(cfg_len_kij), .cfg_len_nij(cfg_len_nij), .cfg_len_onij(cfg_len_onij),
        .cfg_x_base(cfg_x_base), .cfg_w_base(cfg_w_base), .cfg_is_os(cfg_is_os),
`ifdef SEQ_ABORT_EN
        .abort(abort),
`endif
        .CEN_xmem(CEN_xmem), .WEN_xmem(WEN_xmem), .A_xmem(A_xmem), .inst_w(inst_w),
        .kij(kij), .is_os(is_os), .readout_start(readout_start), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        cen;
        logic [1:0]  inst;
        logic [10:0] addr;
        logic [3:0]  k;
        logic        os;
        logic        rs;
        logic        bsy;
        logic        dn;
    } obs_t;

    int   total = 0;
    int   bad = 0;
    obs_t exp_q[$];
    bit   stallv[0:8191];
    logic m_os;
    logic [10:0] iss_q[$];
    int   g_done_c, g_x, g_rs;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    function automatic obs_t mk(logic cen, logic [1:0] inst, logic [10:0] addr,
                                logic [3:0] k, logic rs, logic bsy, logic dn);
        obs_t o;
        o.cen = cen; o.inst = inst; o.addr = addr; o.k = k;
        o.os = m_os; o.rs = rs; o.bsy = bsy; o.dn = dn;
        return o;
    endfunction

    task automatic push_idle(input int n, input logic [3:0] k);
        for (int i = 0; i < n; i++) exp_q.push_back(mk(1'b1, 2'b00, 11'd0, k, 1'b0, 1'b1, 1'b0));
    endtask

    // Words of one load phase in order; a stall seen while words remain costs one bubble
    task automatic push_load(input logic [1:0] inst, input logic [10:0] base, input int n,
                             input logic [3:0] k);
        int i;
        bit bub;
        i = 0;
        bub = 1'b0;
        while (i < n) begin
            if (bub) exp_q.push_back(mk(1'b1, 2'b00, 11'd0, k, 1'b0, 1'b1, 1'b0));
            else begin
                exp_q.push_back(mk(1'b0, inst, 11'(base + 11'(i)), k, 1'b0, 1'b1, 1'b0));
                i++;
            end
            bub = stallv[exp_q.size()] && (i < n);
        end
    endtask

    task automatic build_trace(input int nk, input int nij, input int onij,
                               input logic [10:0] xb, input logic [10:0] wb, input logic os);
        logic [3:0] lastk;
        exp_q.delete();
        m_os = os;
        for (int k = 0; k < nk; k++) begin
            push_load(2'b01, 11'(wb + 11'(k * COL)), COL, 4'(k));
            push_idle(GAP, 4'(k));
            if (nij != 0) push_load(2'b10, xb, nij, 4'(k));
            push_idle(DRN, 4'(k));
        end
        lastk = (nk == 0) ? 4'd0 : 4'(nk - 1);
        if (nk != 0) begin
            exp_q.push_back(mk(1'b1, 2'b00, 11'd0, lastk, 1'b1, 1'b1, 1'b0));
            push_idle(onij, lastk);
        end
        exp_q.push_back(mk(1'b1, 2'b00, 11'd0, lastk, 1'b0, 1'b1, 1'b1));
        exp_q.push_back(mk(1'b1, 2'b00, 11'd0, lastk, 1'b0, 1'b0, 1'b0));
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.cen = CEN_xmem; o.inst = inst_w; o.addr = A_xmem; o.k = kij;
        o.os = is_os; o.rs = readout_start; o.bsy = busy; o.dn = done;
        return o;
    endfunction

    // cut_kind: 0 none, 1 reset, 2 abort; applied so it is sampled at edge start+cut_at
    task automatic run_seq(input int nk, input int nij, input int onij,
                           input logic [10:0] xb, input logic [10:0] wb, input logic os,
                           input int cut_at, input int cut_kind, input bit poke);
        obs_t o, e;
        build_trace(nk, nij, onij, xb, wb, os);
        iss_q.delete();
        g_done_c = -1; g_x = 0; g_rs = 0;
        cfg_len_kij = 4'(nk); cfg_len_nij = 8'(nij); cfg_len_onij = 8'(onij);
        cfg_x_base = xb; cfg_w_base = wb; cfg_is_os = os;
        start = 1'b1;
        stall = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        stall = stallv[1];
        for (int c = 1; c <= exp_q.size(); c++) begin
            @(posedge clk); #1;
            o = sample();
            if (c == cut_at) begin
                if (cut_kind == 1) chk("reset_mid_run", 32'(o), 32'(obs_t'(24'h200000)));
                else chk("abort_outputs", 32'({o.cen, o.inst, o.rs, o.bsy, o.dn}), 32'(6'b100000));
                reset = 1'b0;
                abort = 1'b0;
                stall = 1'b0;
                break;
            end
            e = exp_q[c-1];
            if (e.cen) o.addr = 11'd0;
            chk($sformatf("trace_c%0d", c), 32'(o), 32'(e));
            if (!CEN_xmem) iss_q.push_back(A_xmem);
            if (inst_w == 2'b10) g_x++;
            if (readout_start) g_rs++;
            if (done) g_done_c = c;
            stall = stallv[c+1];
            if (c + 1 == cut_at) begin
                if (cut_kind == 1) reset = 1'b1;
                if (cut_kind == 2) abort = 1'b1;
            end
            if (poke && c == 29) begin
                start = 1'b1;
                cfg_len_kij = 4'd2; cfg_len_nij = 8'd5; cfg_len_onij = 8'd3;
                cfg_x_base = 11'h123; cfg_w_base = 11'h055; cfg_is_os = ~os;
            end
            if (poke && c == 30) start = 1'b0;
        end
    endtask

    function automatic int seq_len(int nk, int nij, int onij);
        // Edge index (from the start-sampling edge) at which done becomes visible;
        // the sequence cycle total also counts the start cycle itself.
        if (nk == 0) return 1;
        return 1 + nk * (COL + GAP + nij + DRN) + 1 + onij + 1 - 1;
    endfunction

    initial begin
        int nk, nij, onij, nb, errs;
        logic [10:0] xb, wb;
        for (int i = 0; i < 8192; i++) stallv[i] = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_values", 32'(sample()), 32'(obs_t'(24'h200000)));
        chk("wen_const", 32'(WEN_xmem), 32'd1);
        reset = 1'b0;
        @(posedge clk); #1;

        // Basic nine-kij run
        run_seq(9, 36, 16, 11'h000, 11'h400, 1'b1, -1, 0, 1'b0);
        chk("basic_done_cycle", 32'(g_done_c), 32'(seq_len(9, 36, 16)));
        chk("basic_done_775", 32'(g_done_c + 1), 32'd775);
        chk("basic_issue_cnt", 32'(iss_q.size()), 32'(9 * (COL + 36)));
        chk("basic_kij3_first", 32'(iss_q[3 * 44]), 32'h418);
        chk("basic_kij3_last", 32'(iss_q[3 * 44 + 7]), 32'h41F);
        chk("basic_rs_pulses", 32'(g_rs), 32'd1);

        // Three stall cycles over activation t=5 of kij 0
        stallv[23] = 1'b1; stallv[24] = 1'b1; stallv[25] = 1'b1;
        run_seq(9, 36, 16, 11'h000, 11'h400, 1'b0, -1, 0, 1'b0);
        chk("stall_done_delay", 32'(g_done_c), 32'(seq_len(9, 36, 16) + 3));
        errs = 0;
        for (int i = 0; i < 36; i++) if (iss_q[8 + i] !== 11'(i)) errs++;
        chk("stall_act_seq", 32'(errs), 32'd0);
        for (int i = 23; i <= 25; i++) stallv[i] = 1'b0;

        // Zero kernel positions: done right away, no issue
        run_seq(0, 10, 4, 11'h010, 11'h020, 1'b1, -1, 0, 1'b0);
        chk("kij0_done_cycle", 32'(g_done_c), 32'd1);
        chk("kij0_no_issue", 32'(iss_q.size()), 32'd0);

        // No activation words
        run_seq(3, 0, 5, 11'h010, 11'h100, 1'b0, -1, 0, 1'b0);
        chk("nij0_no_act", 32'(g_x), 32'd0);
        chk("nij0_done_cycle", 32'(g_done_c), 32'(seq_len(3, 0, 5)));

        // Weight address wrap
        run_seq(1, 4, 2, 11'h7F0, 11'h7FC, 1'b0, -1, 0, 1'b0);
        chk("wrap_7ff", 32'(iss_q[3]), 32'h7FF);
        chk("wrap_000", 32'(iss_q[4]), 32'h000);

        // Start and cfg change while busy
        run_seq(9, 36, 16, 11'h000, 11'h400, 1'b0, -1, 0, 1'b1);
        chk("poke_done_cycle", 32'(g_done_c), 32'(seq_len(9, 36, 16)));
        chk("poke_issue_cnt", 32'(iss_q.size()), 32'(9 * (COL + 36)));

        // Reset during kij 4 activation load, then a full replay
        run_seq(9, 36, 16, 11'h000, 11'h400, 1'b1, 1 + 4 * 84 + 18 + 10, 1, 1'b0);
        run_seq(9, 36, 16, 11'h000, 11'h400, 1'b1, -1, 0, 1'b0);
        chk("replay_done_cycle", 32'(g_done_c), 32'(seq_len(9, 36, 16)));

`ifdef SEQ_ABORT_EN
        // Abort during kij 2 weight gap
        run_seq(9, 36, 16, 11'h000, 11'h400, 1'b0, 1 + 2 * 84 + 8 + 3, 2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("abort_quiet", 32'({readout_start, done, busy, CEN_xmem}), 32'(4'b0001));
        end
        run_seq(9, 36, 16, 11'h000, 11'h400, 1'b0, -1, 0, 1'b0);
        chk("abort_rerun_done", 32'(g_done_c), 32'(seq_len(9, 36, 16)));
`endif

        // Random configurations with random stall everywhere
        for (int r = 0; r < 6; r++) begin
            nk = int'($urandom_range(1, 4));
            nij = int'($urandom_range(0, 20));
            onij = int'($urandom_range(0, 10));
            xb = 11'($urandom);
            wb = 11'($urandom);
            for (int i = 0; i < 8192; i++) stallv[i] = ($urandom_range(0, 3) == 0);
            run_seq(nk, nij, onij, xb, wb, 1'($urandom), -1, 0, 1'b0);
            nb = exp_q.size() - 1 - seq_len(nk, nij, onij);
            chk("rand_issue_cnt", 32'(iss_q.size()), 32'(nk * (COL + nij)));
            chk("rand_done_cycle", 32'(g_done_c), 32'(seq_len(nk, nij, onij) + nb));
        end
        for (int i = 0; i < 8192; i++) stallv[i] = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
